// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter with round-robin grant and
// an ack watchdog that aborts stalled transfers and reports an error to the owner.
module wb_arbiter_2m #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1024,
    parameter int TMR_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam bit                   WD_EN    = (TIMEOUT != 0);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_MAX  = {TMR_WIDTH{1'b1}};

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   last_gnt_r;
    logic [1:0]             gnt_r;
    logic [TMR_WIDTH-1:0]   timer_r;
    logic                   expire_s;
    logic                   abort_cyc_s;

    function automatic logic [TMR_WIDTH-1:0] sat_inc(input logic [TMR_WIDTH-1:0] v);
        if (v == TMR_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(TMR_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Route the owning master onto the slave bus and the slave response back to it.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = {ADDR_WIDTH{1'b0}};
        s_dat_o  = {DATA_WIDTH{1'b0}};
        m0_ack_o = 1'b0;
        m0_dat_o = {DATA_WIDTH{1'b0}};
        m1_ack_o = 1'b0;
        m1_dat_o = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    // An ack in the expiry cycle takes precedence over the abort.
    assign expire_s    = WD_EN && s_stb_o && !s_ack_i && (timer_r == TMR_LAST);
    assign m0_err_o    = expire_s && (state_r == ST_GNT0);
    assign m1_err_o    = expire_s && (state_r == ST_GNT1);
    assign timeout_o   = expire_s;
    assign abort_cyc_s = last_gnt_r ? m1_cyc_i : m0_cyc_i;
    assign gnt_o       = gnt_r;

    // Next-state arbitration: round-robin on ties, direct handover when the owner leaves.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt_s = last_gnt_r ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt_s = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt_s = ST_GNT1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (expire_s) begin
                    state_nxt_s = ST_ABORT;
                end else if (!m0_cyc_i) begin
                    state_nxt_s = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (expire_s) begin
                    state_nxt_s = ST_ABORT;
                end else if (!m1_cyc_i) begin
                    state_nxt_s = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT1;
                end
            end
            ST_ABORT: begin
                if (!abort_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant vector and last-owner registers; last_gnt_r also names the aborted master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= 2'b00;
            last_gnt_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= {state_nxt_s == ST_GNT1, state_nxt_s == ST_GNT0};
            if (state_nxt_s == ST_GNT0) begin
                last_gnt_r <= 1'b0;
            end else if (state_nxt_s == ST_GNT1) begin
                last_gnt_r <= 1'b1;
            end
        end
    end

    // Watchdog: counts unacknowledged strobe cycles within one grant, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TMR_WIDTH{1'b0}};
        end else if (!WD_EN || (state_nxt_s != state_r) || !s_stb_o || s_ack_i) begin
            timer_r <= {TMR_WIDTH{1'b0}};
        end else begin
            timer_r <= sat_inc(timer_r);
        end
    end

endmodule
